// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen
// ------------
// Front end for an SR latch. Each raw push-button input (set, reset) goes
// through a 2-flop synchroniser and a debounce counter. Every 0->1 change of
// a debounced level raises that channel's pending request. A small FSM turns
// each pending request into a clean PULSE_LEN-cycle S or R pulse. S and R are
// never high in the same cycle.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive clocks the synchronised input must differ
//                    from the stable level before the level flips (2..65535)
//   PULSE_LEN        width of each S / R pulse in clocks (1..255)
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   btn_set      raw asynchronous set button
//   btn_reset    raw asynchronous reset button
//   S            set pulse to the latch
//   R            reset pulse to the latch
//   set_level    debounced level of btn_set
//   reset_level  debounced level of btn_reset
//   conflict     one-cycle flag: simultaneous set/reset requests arbitrated
//
// Build option:
//   SR_PULSE_RESET_PRIORITY_EN  when defined, a simultaneous request issues an
//                               R pulse (reset wins). When undefined, both
//                               requests are dropped and only conflict pulses.

module sr_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN       = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_set,
    input  logic btn_reset,
    output logic S,
    output logic R,
    output logic set_level,
    output logic reset_level,
    output logic conflict
);

    localparam int NCH = 2;  // channel 0 = set, channel 1 = reset
    localparam int DW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    // Keep the pulse counter at least one bit wide so PULSE_LEN=1 works.
    localparam int PW  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0] PLS_MAX = PW'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SET_P = 2'd1,
        RST_P = 2'd2
    } state_e;

    logic [NCH-1:0] btn;
    logic [NCH-1:0] level;
    logic [NCH-1:0] rise;

    assign btn = {btn_reset, btn_set};

    // ------------------------------------------------------------------
    // Per-channel synchroniser + debouncer
    // ------------------------------------------------------------------
    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [1:0]    sync_q;
        logic          stable_q, stable_d;
        logic [DW-1:0] cnt_q, cnt_d;

        // Any sample that agrees with the stable level clears the count, so
        // a bounce restarts the qualification window.
        always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (sync_q[1] != stable_q) begin
                if (cnt_q == DB_MAX) begin
                    stable_d = sync_q[1];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q   <= '0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync_q   <= {sync_q[0], btn[ch]};
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign level[ch] = stable_q;
        // Look-ahead so the pending flag sets on the same edge as the level.
        assign rise[ch]  = stable_d & ~stable_q;
    end

    // ------------------------------------------------------------------
    // Request flags and pulse FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          set_pend_q, set_pend_d;
    logic          rst_pend_q, rst_pend_d;
    logic          conflict_q, conflict_d;

    always_comb begin
        state_d    = state_q;
        pcnt_d     = '0;
        // New presses latch in any state; a press while already pending is
        // simply absorbed by the OR.
        set_pend_d = set_pend_q | rise[0];
        rst_pend_d = rst_pend_q | rise[1];
        conflict_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (set_pend_q && rst_pend_q) begin
                    conflict_d = 1'b1;
                    set_pend_d = rise[0];
                    rst_pend_d = rise[1];
`ifdef SR_PULSE_RESET_PRIORITY_EN
                    state_d    = RST_P;
`else
                    state_d    = IDLE;
`endif
                end else if (set_pend_q) begin
                    set_pend_d = rise[0];
                    state_d    = SET_P;
                end else if (rst_pend_q) begin
                    rst_pend_d = rise[1];
                    state_d    = RST_P;
                end
            end
            SET_P, RST_P: begin
                // Always fall back to IDLE, which guarantees one idle cycle
                // between consecutive pulses.
                if (pcnt_q == PLS_MAX) begin
                    state_d = IDLE;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pcnt_q     <= '0;
            set_pend_q <= 1'b0;
            rst_pend_q <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pcnt_q     <= pcnt_d;
            set_pend_q <= set_pend_d;
            rst_pend_q <= rst_pend_d;
            conflict_q <= conflict_d;
        end
    end

    // Decoded straight from the state register: glitch-free, mutually
    // exclusive by construction, and dropped immediately by async reset.
    assign S           = (state_q == SET_P);
    assign R           = (state_q == RST_P);
    assign conflict    = conflict_q;
    assign set_level   = level[0];
    assign reset_level = level[1];

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Testbench for sr_pulse_gen with DEBOUNCE_CYCLES=4, PULSE_LEN=2.
// Each scenario pushes its expected per-cycle output vector
// {S, R, conflict, set_level, reset_level} into a scoreboard queue and pops
// one entry after every clock edge to compare against the DUT.

module tb_sr_pulse_gen;

    localparam int DEB = 4;
    localparam int PL  = 2;

    typedef logic [4:0] exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_set = 1'b0;
    logic btn_reset = 1'b0;
    logic S, R, set_level, reset_level, conflict;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    sr_pulse_gen #(.DEBOUNCE_CYCLES(DEB), .PULSE_LEN(PL)) dut (
        .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_reset(btn_reset),
        .S(S), .R(R), .set_level(set_level), .reset_level(reset_level),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    logic [4:0] obs;
    assign obs = {S, R, conflict, set_level, reset_level};

    // S and R must never be high together.
    always @(negedge clk) begin
        total++;
        if (S && R) begin
            bad++;
            $display("FAIL excl t=%0t S=%b R=%b required not both 1", $time, S, R);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        btn_set = 1'b0;
        btn_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        // Buttons toggle while reset is held: everything stays 0.
        for (int k = 0; k < 8; k++) sb.push_back(5'b0);
        for (int k = 0; k < 8; k++) begin
            btn_set = 1'($urandom);
            btn_reset = 1'($urandom);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_hold k=%0d got=%b want=%b", k, obs, e);
            end
        end
        btn_set = 1'b0;
        btn_reset = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) sb.push_back(5'b0);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_release k=%0d got=%b want=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_clean_press();
        exp_t e;
        do_reset();
        btn_set = 1'b1;  // first sampled at edge 0
        for (int k = 0; k < 12; k++)
            sb.push_back({(k == 6 || k == 7), 1'b0, 1'b0, (k >= 5), 1'b0});
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL clean k=%0d got=%b want=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        do_reset();
        btn_set = 1'b1;
        for (int k = 0; k < 7; k++)
            sb.push_back({(k == 6), 1'b0, 1'b0, (k >= 5), 1'b0});
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL midpulse_pre k=%0d got=%b want=%b", k, obs, e);
            end
        end
        // S is high now; drop reset between edges.
        sb.push_back(5'b0);
        #2 rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL midpulse_async got=%b want=%b", obs, e);
        end
        btn_set = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_bounce();
        exp_t e;
        do_reset();
        btn_reset = 1'b1;  // raw sampled: 1,0,1,0 then 1 from edge 4
        for (int k = 0; k < 15; k++)
            sb.push_back({1'b0, (k == 10 || k == 11), 1'b0, 1'b0, (k >= 9)});
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            btn_reset = (k == 0 || k == 2) ? 1'b0 : 1'b1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL bounce k=%0d got=%b want=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_overlap();
        exp_t e;
        do_reset();
        btn_set = 1'b1;  // set sampled from edge 0, reset from edge 1
        for (int k = 0; k < 14; k++)
            sb.push_back({(k == 6 || k == 7), (k == 9 || k == 10), 1'b0,
                          (k >= 5), (k >= 6)});
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (k == 0) btn_reset = 1'b1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL overlap k=%0d got=%b want=%b", k, obs, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        logic rpulse;
        do_reset();
        btn_set = 1'b1;
        btn_reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
`ifdef SR_PULSE_RESET_PRIORITY_EN
            rpulse = (k == 6 || k == 7);
`else
            rpulse = 1'b0;
`endif
            sb.push_back({1'b0, rpulse, (k == 6), (k >= 5), (k >= 5)});
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL simul k=%0d got=%b want=%b", k, obs, e);
            end
        end
    endtask

    // Follows test_simultaneous: both levels are high, no pulse in flight.
    task automatic test_release();
        exp_t e;
        btn_set = 1'b0;
        btn_reset = 1'b0;
        for (int k = 0; k < 10; k++)
            sb.push_back({1'b0, 1'b0, 1'b0, (k < 5), (k < 5)});
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL release k=%0d got=%b want=%b", k, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_async_reset();
        test_bounce();
        test_overlap();
        test_simultaneous();
        test_release();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
